// File: rtl/eth_rx_hdr_parser.sv
// Ethernet II / IPv4 header parser on the 10G MAC RX AXI-Stream (64-bit, no backpressure).
// Walks the first five beats of each frame, captures the L2/L3 header fields into shadow
// registers, accumulates a saturating byte count and emits one registered descriptor on
// the cycle after each tlast beat, together with good/drop frame counters.
module eth_rx_hdr_parser #(
  parameter logic [47:0] LOCAL_MAC = 48'h000A35000001
) (
  input  logic        clk156,
  input  logic        eth_rst,
  input  logic        s_axis_rx_tvalid,
  input  logic [63:0] s_axis_rx_tdata,
  input  logic [7:0]  s_axis_rx_tkeep,
  input  logic        s_axis_rx_tlast,
  input  logic        s_axis_rx_tuser,
  output logic        hdr_valid,
  output logic [47:0] hdr_dst_mac,
  output logic [47:0] hdr_src_mac,
  output logic [15:0] hdr_ethertype,
  output logic [7:0]  hdr_ip_proto,
  output logic [31:0] hdr_src_ip,
  output logic [31:0] hdr_dst_ip,
  output logic [15:0] hdr_byte_cnt,
  output logic        hdr_mac_match,
  output logic        hdr_is_ipv4,
  output logic        hdr_good,
  output logic [31:0] frame_cnt,
  output logic [31:0] drop_cnt
);

  localparam logic [47:0] BCAST_MAC   = '1;
  localparam logic [15:0] ETYPE_IPV4  = 16'h0800;
  localparam logic [15:0] MIN_ETH_LEN = 16'd14;
  localparam logic [15:0] MIN_IP_LEN  = 16'd34;

  // Beat position within the frame; beat n carries wire bytes 8n..8n+7.
  typedef enum logic [2:0] {
    BEAT0,
    HDR1,
    HDR2,
    HDR3,
    HDR4,
    PAYLOAD
  } state_t;

  state_t state_q, state_d;

  // Shadow header fields for the frame in flight.
  logic [47:0] dst_q,   dst_d;
  logic [47:0] src_q,   src_d;
  logic [15:0] etype_q, etype_d;
  logic [3:0]  ipver_q, ipver_d;
  logic [7:0]  proto_q, proto_d;
  logic [31:0] sip_q,   sip_d;
  logic [31:0] dip_q,   dip_d;
  logic [15:0] cnt_q,   cnt_d;

  // Registered descriptor and counters.
  logic        valid_q;
  logic [47:0] out_dst_q;
  logic [47:0] out_src_q;
  logic [15:0] out_etype_q;
  logic [7:0]  out_proto_q;
  logic [31:0] out_sip_q;
  logic [31:0] out_dip_q;
  logic [15:0] out_cnt_q;
  logic        out_match_q;
  logic        out_ipv4_q;
  logic        out_good_q;
  logic [31:0] frame_cnt_q;
  logic [31:0] drop_cnt_q;

  logic [3:0]  keep_pop;
  logic [15:0] cnt_base;
  logic [16:0] cnt_sum;
  logic        end_beat;
  logic        desc_match;
  logic        desc_ipv4;
  logic        desc_good;

  assign end_beat = s_axis_rx_tvalid & s_axis_rx_tlast;

  // Number of enabled bytes in the current beat (tkeep need not be contiguous).
  always_comb begin
    keep_pop = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      keep_pop = keep_pop + {3'b000, s_axis_rx_tkeep[i]};
    end
  end

  // Running byte count; restarts on the first beat of a frame and saturates at all-ones.
  always_comb begin
    cnt_base = (state_q == BEAT0) ? '0 : cnt_q;
    cnt_sum  = {1'b0, cnt_base} + {13'b0, keep_pop};
    cnt_d    = cnt_q;
    if (s_axis_rx_tvalid) begin
      cnt_d = cnt_sum[16] ? '1 : cnt_sum[15:0];
    end
  end

  // Next beat position and shadow field capture for each valid beat.
  always_comb begin
    state_d = state_q;
    dst_d   = dst_q;
    src_d   = src_q;
    etype_d = etype_q;
    ipver_d = ipver_q;
    proto_d = proto_q;
    sip_d   = sip_q;
    dip_d   = dip_q;
    if (s_axis_rx_tvalid) begin
      unique case (state_q)
        BEAT0: begin
          // The first beat also clears every field a short frame might never reach.
          dst_d   = {s_axis_rx_tdata[7:0],   s_axis_rx_tdata[15:8],
                     s_axis_rx_tdata[23:16], s_axis_rx_tdata[31:24],
                     s_axis_rx_tdata[39:32], s_axis_rx_tdata[47:40]};
          src_d   = {s_axis_rx_tdata[55:48], s_axis_rx_tdata[63:56], 32'h0};
          etype_d = '0;
          ipver_d = '0;
          proto_d = '0;
          sip_d   = '0;
          dip_d   = '0;
          state_d = HDR1;
        end
        HDR1: begin
          src_d[31:0] = {s_axis_rx_tdata[7:0],   s_axis_rx_tdata[15:8],
                         s_axis_rx_tdata[23:16], s_axis_rx_tdata[31:24]};
          etype_d     = {s_axis_rx_tdata[39:32], s_axis_rx_tdata[47:40]};
          ipver_d     = s_axis_rx_tdata[55:52];
          state_d     = HDR2;
        end
        HDR2: begin
          proto_d = s_axis_rx_tdata[63:56];
          state_d = HDR3;
        end
        HDR3: begin
          sip_d   = {s_axis_rx_tdata[23:16], s_axis_rx_tdata[31:24],
                     s_axis_rx_tdata[39:32], s_axis_rx_tdata[47:40]};
          dip_d   = {s_axis_rx_tdata[55:48], s_axis_rx_tdata[63:56], 16'h0};
          state_d = HDR4;
        end
        HDR4: begin
          dip_d[15:0] = {s_axis_rx_tdata[7:0], s_axis_rx_tdata[15:8]};
          state_d     = PAYLOAD;
        end
        PAYLOAD: state_d = PAYLOAD;
        default: state_d = BEAT0;
      endcase
      if (s_axis_rx_tlast) begin
        state_d = BEAT0;
      end
    end
  end

  // Classification uses the next-state shadow so the tlast beat's own bytes are included.
  always_comb begin
    desc_match = (dst_d == LOCAL_MAC) || (dst_d == BCAST_MAC);
    desc_ipv4  = (etype_d == ETYPE_IPV4) && (ipver_d == 4'h4) && (cnt_d >= MIN_IP_LEN);
    desc_good  = s_axis_rx_tuser && (cnt_d >= MIN_ETH_LEN);
  end

  // Beat position and shadow header registers.
  always_ff @(posedge clk156 or posedge eth_rst) begin
    if (eth_rst) begin
      state_q <= BEAT0;
      dst_q   <= '0;
      src_q   <= '0;
      etype_q <= '0;
      ipver_q <= '0;
      proto_q <= '0;
      sip_q   <= '0;
      dip_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dst_q   <= dst_d;
      src_q   <= src_d;
      etype_q <= etype_d;
      ipver_q <= ipver_d;
      proto_q <= proto_d;
      sip_q   <= sip_d;
      dip_q   <= dip_d;
      cnt_q   <= cnt_d;
    end
  end

  // Descriptor is loaded on the tlast beat and held until the next one; counters wrap.
  always_ff @(posedge clk156 or posedge eth_rst) begin
    if (eth_rst) begin
      valid_q     <= 1'b0;
      out_dst_q   <= '0;
      out_src_q   <= '0;
      out_etype_q <= '0;
      out_proto_q <= '0;
      out_sip_q   <= '0;
      out_dip_q   <= '0;
      out_cnt_q   <= '0;
      out_match_q <= 1'b0;
      out_ipv4_q  <= 1'b0;
      out_good_q  <= 1'b0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      valid_q <= end_beat;
      if (end_beat) begin
        out_dst_q   <= dst_d;
        out_src_q   <= src_d;
        out_etype_q <= etype_d;
        out_proto_q <= proto_d;
        out_sip_q   <= sip_d;
        out_dip_q   <= dip_d;
        out_cnt_q   <= cnt_d;
        out_match_q <= desc_match;
        out_ipv4_q  <= desc_ipv4;
        out_good_q  <= desc_good;
        if (desc_good) begin
          frame_cnt_q <= frame_cnt_q + 32'd1;
        end else begin
          drop_cnt_q  <= drop_cnt_q + 32'd1;
        end
      end
    end
  end

  assign hdr_valid     = valid_q;
  assign hdr_dst_mac   = out_dst_q;
  assign hdr_src_mac   = out_src_q;
  assign hdr_ethertype = out_etype_q;
  assign hdr_ip_proto  = out_proto_q;
  assign hdr_src_ip    = out_sip_q;
  assign hdr_dst_ip    = out_dip_q;
  assign hdr_byte_cnt  = out_cnt_q;
  assign hdr_mac_match = out_match_q;
  assign hdr_is_ipv4   = out_ipv4_q;
  assign hdr_good      = out_good_q;
  assign frame_cnt     = frame_cnt_q;
  assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_eth_rx_hdr_parser.sv
// Self-checking bench for eth_rx_hdr_parser: frames are built byte-by-byte, the expected
// descriptor is derived from the wire bytes and queued when the tlast beat is driven,
// and a monitor pops and compares it when hdr_valid is seen.
`timescale 1ns/1ps
module tb_eth_rx_hdr_parser;

  logic        clk156 = 1'b0;
  logic        eth_rst;
  logic        s_axis_rx_tvalid;
  logic [63:0] s_axis_rx_tdata;
  logic [7:0]  s_axis_rx_tkeep;
  logic        s_axis_rx_tlast;
  logic        s_axis_rx_tuser;
  logic        hdr_valid;
  logic [47:0] hdr_dst_mac;
  logic [47:0] hdr_src_mac;
  logic [15:0] hdr_ethertype;
  logic [7:0]  hdr_ip_proto;
  logic [31:0] hdr_src_ip;
  logic [31:0] hdr_dst_ip;
  logic [15:0] hdr_byte_cnt;
  logic        hdr_mac_match;
  logic        hdr_is_ipv4;
  logic        hdr_good;
  logic [31:0] frame_cnt;
  logic [31:0] drop_cnt;

  eth_rx_hdr_parser #(.LOCAL_MAC(48'h000A35000001)) dut (
    .clk156           (clk156),
    .eth_rst          (eth_rst),
    .s_axis_rx_tvalid (s_axis_rx_tvalid),
    .s_axis_rx_tdata  (s_axis_rx_tdata),
    .s_axis_rx_tkeep  (s_axis_rx_tkeep),
    .s_axis_rx_tlast  (s_axis_rx_tlast),
    .s_axis_rx_tuser  (s_axis_rx_tuser),
    .hdr_valid        (hdr_valid),
    .hdr_dst_mac      (hdr_dst_mac),
    .hdr_src_mac      (hdr_src_mac),
    .hdr_ethertype    (hdr_ethertype),
    .hdr_ip_proto     (hdr_ip_proto),
    .hdr_src_ip       (hdr_src_ip),
    .hdr_dst_ip       (hdr_dst_ip),
    .hdr_byte_cnt     (hdr_byte_cnt),
    .hdr_mac_match    (hdr_mac_match),
    .hdr_is_ipv4      (hdr_is_ipv4),
    .hdr_good         (hdr_good),
    .frame_cnt        (frame_cnt),
    .drop_cnt         (drop_cnt)
  );

  always #3.2 clk156 = ~clk156;

  typedef struct {
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] etype;
    logic [7:0]  proto;
    logic [31:0] sip;
    logic [31:0] dip;
    logic [15:0] cnt;
    logic        match;
    logic        ipv4;
    logic        good;
    logic [31:0] fcnt;
    logic [31:0] dcnt;
    int          tl_cyc;
  } desc_t;

  desc_t       sbq[$];
  desc_t       mon_e;
  logic [7:0]  fb [0:255];
  int          n_checks   = 0;
  int          n_errors   = 0;
  int          n_pulses   = 0;
  int          cyc        = 0;
  int          exp_frames = 0;
  int          exp_drops  = 0;

  always @(posedge clk156) cyc <= cyc + 1;

  function automatic int pop8(input logic [7:0] k);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(k[i]);
    return n;
  endfunction

  function automatic logic [7:0] fbyte(input int i);
    return (i < 256) ? fb[i] : 8'hA5;
  endfunction

  task automatic put(input int nb, input int idx, input logic [7:0] v);
    if (idx < nb * 8 && idx < 256) fb[idx] = v;
  endtask

  task automatic build_frame(input logic [47:0] dst, input logic [47:0] src,
                             input logic [15:0] et, input logic [7:0] b14,
                             input logic [7:0] proto, input logic [31:0] sip,
                             input logic [31:0] dip, input int nb, input logic [7:0] lk);
    for (int i = 0; i < 256; i++) fb[i] = (i < nb * 8) ? 8'(i * 7 + 3) : 8'h00;
    for (int k = 0; k < 6; k++) begin
      put(nb, k,     dst[47 - 8 * k -: 8]);
      put(nb, 6 + k, src[47 - 8 * k -: 8]);
    end
    put(nb, 12, et[15:8]);
    put(nb, 13, et[7:0]);
    put(nb, 14, b14);
    put(nb, 23, proto);
    for (int k = 0; k < 4; k++) begin
      put(nb, 26 + k, sip[31 - 8 * k -: 8]);
      put(nb, 30 + k, dip[31 - 8 * k -: 8]);
    end
    for (int b = 0; b < 8; b++) if (!lk[b]) put(nb, (nb - 1) * 8 + b, 8'h00);
  endtask

  function automatic desc_t model(input int nb, input logic [7:0] lk, input logic tu);
    desc_t d;
    int raw;
    raw     = 8 * (nb - 1) + pop8(lk);
    d.cnt   = (raw > 65535) ? 16'hFFFF : 16'(raw);
    d.dst   = {fb[0], fb[1], fb[2], fb[3], fb[4], fb[5]};
    d.src   = {fb[6], fb[7], fb[8], fb[9], fb[10], fb[11]};
    d.etype = {fb[12], fb[13]};
    d.proto = fb[23];
    d.sip   = {fb[26], fb[27], fb[28], fb[29]};
    d.dip   = {fb[30], fb[31], fb[32], fb[33]};
    d.match = (d.dst == 48'h000A35000001) || (d.dst == 48'hFFFFFFFFFFFF);
    d.ipv4  = (d.etype == 16'h0800) && (fb[14][7:4] == 4'h4) && (d.cnt >= 16'd34);
    d.good  = tu && (d.cnt >= 16'd14);
    d.fcnt  = '0;
    d.dcnt  = '0;
    d.tl_cyc = 0;
    return d;
  endfunction

  task automatic drive_beat(input int idx, input logic [7:0] keep, input logic last, input logic user);
    @(posedge clk156); #1;
    s_axis_rx_tvalid = 1'b1;
    for (int b = 0; b < 8; b++) s_axis_rx_tdata[8 * b +: 8] = fbyte(idx * 8 + b);
    s_axis_rx_tkeep = keep;
    s_axis_rx_tlast = last;
    s_axis_rx_tuser = user;
  endtask

  // Idle cycles carry junk on every other signal; none of it may be consumed.
  task automatic drive_idle(input int n);
    repeat (n) begin
      @(posedge clk156); #1;
      s_axis_rx_tvalid = 1'b0;
      s_axis_rx_tdata  = {$urandom, $urandom};
      s_axis_rx_tkeep  = 8'($urandom);
      s_axis_rx_tlast  = 1'($urandom);
      s_axis_rx_tuser  = 1'($urandom);
    end
  endtask

  task automatic send_frame(input int nb, input logic [7:0] lk, input logic tu, input int ngaps);
    desc_t d;
    int gl [16];
    int lim;
    for (int i = 0; i < 16; i++) gl[i] = 0;
    lim = (nb > 16) ? 16 : nb;
    for (int g = 0; g < ngaps; g++) gl[$urandom_range(1, lim - 1)] += 1;
    d = model(nb, lk, tu);
    if (d.good) exp_frames++; else exp_drops++;
    d.fcnt = 32'(exp_frames);
    d.dcnt = 32'(exp_drops);
    for (int b = 0; b < nb; b++) begin
      if (b < 16 && gl[b] > 0) drive_idle(gl[b]);
      if (b == nb - 1) begin
        drive_beat(b, lk, 1'b1, tu);
        d.tl_cyc = cyc;
        sbq.push_back(d);
      end else begin
        drive_beat(b, 8'hFF, 1'b0, 1'b0);
      end
    end
  endtask

  task automatic drain();
    int w = 0;
    drive_idle(2);
    while (sbq.size() != 0 && w < 50) begin
      @(negedge clk156);
      w++;
    end
    n_checks++;
    if (sbq.size() != 0) begin
      n_errors++;
      $display("FAIL drain_timeout: %0d descriptors outstanding, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk156); #1;
    eth_rst = 1'b1;
    s_axis_rx_tvalid = 1'b0;
    @(posedge clk156); #1;
    eth_rst = 1'b0;
    exp_frames = 0;
    exp_drops  = 0;
  endtask

  // Scoreboard monitor: pops one expected descriptor per hdr_valid pulse.
  always @(negedge clk156) begin
    if (!eth_rst && hdr_valid) begin
      n_pulses++;
      if (sbq.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL unexpected_hdr_valid: pulse at cycle %0d, required none", cyc);
      end else begin
        mon_e = sbq.pop_front();
        n_checks++; if (cyc !== mon_e.tl_cyc + 1) begin n_errors++; $display("FAIL latency: got cycle %0d, required %0d", cyc, mon_e.tl_cyc + 1); end
        n_checks++; if (hdr_dst_mac !== mon_e.dst) begin n_errors++; $display("FAIL dst_mac: got %h, required %h", hdr_dst_mac, mon_e.dst); end
        n_checks++; if (hdr_src_mac !== mon_e.src) begin n_errors++; $display("FAIL src_mac: got %h, required %h", hdr_src_mac, mon_e.src); end
        n_checks++; if (hdr_ethertype !== mon_e.etype) begin n_errors++; $display("FAIL ethertype: got %h, required %h", hdr_ethertype, mon_e.etype); end
        n_checks++; if (hdr_ip_proto !== mon_e.proto) begin n_errors++; $display("FAIL ip_proto: got %h, required %h", hdr_ip_proto, mon_e.proto); end
        n_checks++; if (hdr_src_ip !== mon_e.sip) begin n_errors++; $display("FAIL src_ip: got %h, required %h", hdr_src_ip, mon_e.sip); end
        n_checks++; if (hdr_dst_ip !== mon_e.dip) begin n_errors++; $display("FAIL dst_ip: got %h, required %h", hdr_dst_ip, mon_e.dip); end
        n_checks++; if (hdr_byte_cnt !== mon_e.cnt) begin n_errors++; $display("FAIL byte_cnt: got %0d, required %0d", hdr_byte_cnt, mon_e.cnt); end
        n_checks++; if (hdr_mac_match !== mon_e.match) begin n_errors++; $display("FAIL mac_match: got %b, required %b", hdr_mac_match, mon_e.match); end
        n_checks++; if (hdr_is_ipv4 !== mon_e.ipv4) begin n_errors++; $display("FAIL is_ipv4: got %b, required %b", hdr_is_ipv4, mon_e.ipv4); end
        n_checks++; if (hdr_good !== mon_e.good) begin n_errors++; $display("FAIL good: got %b, required %b", hdr_good, mon_e.good); end
        n_checks++; if (frame_cnt !== mon_e.fcnt) begin n_errors++; $display("FAIL frame_cnt: got %0d, required %0d", frame_cnt, mon_e.fcnt); end
        n_checks++; if (drop_cnt !== mon_e.dcnt) begin n_errors++; $display("FAIL drop_cnt: got %0d, required %0d", drop_cnt, mon_e.dcnt); end
      end
    end
  end

  task automatic build_ipv4(input int nb, input logic [7:0] lk);
    build_frame(48'h000A35000001, 48'h001122334455, 16'h0800, 8'h45, 8'h11,
                32'h0A000001, 32'h0A000002, nb, lk);
  endtask

  task automatic build_arp();
    build_frame(48'hFFFFFFFFFFFF, 48'h001122334455, 16'h0806, 8'h00, 8'h00,
                32'hC0A80001, 32'hC0A80002, 8, 8'h0F);
  endtask

  task automatic test_reset();
    eth_rst = 1'b1;
    s_axis_rx_tvalid = 1'b0;
    repeat (3) @(posedge clk156);
    #1;
    n_checks++; if (hdr_valid !== 1'b0) begin n_errors++; $display("FAIL reset_hdr_valid: got %b, required 0", hdr_valid); end
    n_checks++; if ({hdr_dst_mac, hdr_src_mac, hdr_ethertype, hdr_ip_proto, hdr_src_ip, hdr_dst_ip, hdr_byte_cnt} !== '0) begin
      n_errors++; $display("FAIL reset_fields: got nonzero descriptor, required 0");
    end
    n_checks++; if ({hdr_mac_match, hdr_is_ipv4, hdr_good} !== 3'b000) begin n_errors++; $display("FAIL reset_flags: got %b, required 000", {hdr_mac_match, hdr_is_ipv4, hdr_good}); end
    n_checks++; if ({frame_cnt, drop_cnt} !== 64'h0) begin n_errors++; $display("FAIL reset_counters: got %0d/%0d, required 0/0", frame_cnt, drop_cnt); end
    @(posedge clk156); #1;
    eth_rst = 1'b0;
    exp_frames = 0;
    exp_drops  = 0;
    drive_idle(2);
  endtask

  task automatic test_ipv4();
    build_ipv4(8, 8'hFF);
    send_frame(8, 8'hFF, 1'b1, 0);
    drain();
    n_checks++; if (frame_cnt !== 32'd1) begin n_errors++; $display("FAIL ipv4_frame_cnt: got %0d, required 1", frame_cnt); end
  endtask

  task automatic test_arp();
    build_arp();
    send_frame(8, 8'h0F, 1'b1, 0);
    drain();
    n_checks++; if (hdr_byte_cnt !== 16'd60) begin n_errors++; $display("FAIL arp_byte_cnt: got %0d, required 60", hdr_byte_cnt); end
    n_checks++; if (frame_cnt !== 32'd2) begin n_errors++; $display("FAIL arp_frame_cnt: got %0d, required 2", frame_cnt); end
  endtask

  task automatic test_bad_fcs();
    build_ipv4(8, 8'hFF);
    send_frame(8, 8'hFF, 1'b0, 0);
    drain();
    n_checks++; if (frame_cnt !== 32'd2 || drop_cnt !== 32'd1) begin
      n_errors++; $display("FAIL badfcs_counters: got %0d/%0d, required 2/1", frame_cnt, drop_cnt);
    end
  endtask

  task automatic test_runt();
    for (int i = 0; i < 256; i++) fb[i] = 8'h00;
    fb[0] = 8'h00;
    fb[1] = 8'h0A;
    send_frame(1, 8'h03, 1'b1, 0);
    drain();
    n_checks++; if (hdr_byte_cnt !== 16'd2 || hdr_good !== 1'b0) begin
      n_errors++; $display("FAIL runt_desc: got cnt %0d good %b, required cnt 2 good 0", hdr_byte_cnt, hdr_good);
    end
    n_checks++; if (drop_cnt !== 32'd2) begin n_errors++; $display("FAIL runt_drop_cnt: got %0d, required 2", drop_cnt); end
  endtask

  task automatic test_noncontig();
    build_ipv4(3, 8'h81);
    send_frame(3, 8'h81, 1'b1, 0);
    drain();
    n_checks++; if (hdr_byte_cnt !== 16'd18) begin n_errors++; $display("FAIL noncontig_byte_cnt: got %0d, required 18", hdr_byte_cnt); end
    n_checks++; if (frame_cnt !== 32'd3) begin n_errors++; $display("FAIL noncontig_frame_cnt: got %0d, required 3", frame_cnt); end
  endtask

  task automatic test_saturate();
    build_ipv4(8200, 8'hFF);
    send_frame(8200, 8'hFF, 1'b1, 0);
    drain();
    n_checks++; if (hdr_byte_cnt !== 16'hFFFF) begin n_errors++; $display("FAIL saturate_byte_cnt: got %h, required ffff", hdr_byte_cnt); end
  endtask

  task automatic test_back_to_back();
    int p0;
    pulse_reset();
    p0 = n_pulses;
    build_ipv4(8, 8'hFF);
    send_frame(8, 8'hFF, 1'b1, 3);
    send_frame(8, 8'hFF, 1'b1, 3);
    drain();
    n_checks++; if (n_pulses - p0 !== 2) begin n_errors++; $display("FAIL b2b_pulses: got %0d, required 2", n_pulses - p0); end
    n_checks++; if (frame_cnt !== 32'd2) begin n_errors++; $display("FAIL b2b_frame_cnt: got %0d, required 2", frame_cnt); end
  endtask

  task automatic test_reset_midframe();
    int p0;
    build_ipv4(8, 8'hFF);
    drive_beat(0, 8'hFF, 1'b0, 1'b0);
    drive_beat(1, 8'hFF, 1'b0, 1'b0);
    drive_beat(2, 8'hFF, 1'b0, 1'b0);
    #1;
    eth_rst = 1'b1;
    #1;
    n_checks++; if ({hdr_dst_mac, hdr_byte_cnt, frame_cnt} !== '0) begin
      n_errors++; $display("FAIL async_reset: got dst %h cnt %0d frames %0d, required all 0", hdr_dst_mac, hdr_byte_cnt, frame_cnt);
    end
    s_axis_rx_tvalid = 1'b0;
    repeat (2) @(posedge clk156);
    #1;
    eth_rst = 1'b0;
    exp_frames = 0;
    exp_drops  = 0;
    p0 = n_pulses;
    build_arp();
    send_frame(8, 8'h0F, 1'b1, 0);
    drain();
    n_checks++; if (n_pulses - p0 !== 1) begin n_errors++; $display("FAIL midrst_pulses: got %0d, required 1", n_pulses - p0); end
    n_checks++; if (frame_cnt !== 32'd1 || hdr_ethertype !== 16'h0806) begin
      n_errors++; $display("FAIL midrst_desc: got frames %0d type %h, required 1 0806", frame_cnt, hdr_ethertype);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    eth_rst          = 1'b1;
    s_axis_rx_tvalid = 1'b0;
    s_axis_rx_tdata  = '0;
    s_axis_rx_tkeep  = '0;
    s_axis_rx_tlast  = 1'b0;
    s_axis_rx_tuser  = 1'b0;
    test_reset();
    test_ipv4();
    test_arp();
    test_bad_fcs();
    test_runt();
    test_noncontig();
    test_saturate();
    test_back_to_back();
    test_reset_midframe();
    drive_idle(4);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
